// File: rtl/gray_pkg.sv
// gray_pkg: shared constants and FSM state type for the 2x gray upscaler.
package gray_pkg;
  localparam int DATA_WIDTH = 12;
  localparam int IN_W = 640;
  localparam int IN_H = 480;
  localparam int COORD_W = 16;
  typedef enum logic [1:0] {EVEN, RPRIME, ODD} state_t;
endpackage

// File: rtl/gray_upscale2x_linebuf.sv
// gray_linebuf: one-line RAM, synchronous write, registered read, no storage reset.
module gray_linebuf #(
  parameter int DATA_WIDTH = 12,
  parameter int DEPTH = 640,
  parameter int AW = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [AW-1:0]         rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/gray_upscale2x.sv
// gray_upscale2x: 2x nearest-neighbour upscaler; each gray pixel is emitted twice and each line replayed once.
module gray_upscale2x #(
  parameter int DATA_WIDTH = gray_pkg::DATA_WIDTH,
  parameter int IN_W = gray_pkg::IN_W,
  parameter int IN_H = gray_pkg::IN_H
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DATA_WIDTH-1:0]        in_pixel,
  input  logic                         in_valid,
  input  logic                         in_sof,
  output logic                         in_ready,
  output logic [DATA_WIDTH-1:0]        out_pixel,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [gray_pkg::COORD_W-1:0] out_col,
  output logic [gray_pkg::COORD_W-1:0] out_row,
  output logic                         out_sof,
  output logic                         out_eol
);
  import gray_pkg::*;
  localparam int AW = (IN_W > 1) ? $clog2(IN_W) : 1;
  localparam logic [COORD_W-1:0] LAST_COL = COORD_W'(2 * IN_W - 1);
  localparam logic [COORD_W-1:0] LAST_ROW = COORD_W'(2 * IN_H - 1);
  state_t state, next_state;
  logic phase, in_fire, out_fire, last_col, last_row, last_in_row;
  logic [COORD_W-1:0] in_col, in_row;
  logic [AW-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  gray_linebuf #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IN_W), .AW(AW)) linebuf (
    .clk(clk),
    .we(in_fire),
    .wr_addr(in_sof ? '0 : in_col[AW-1:0]),
    .wr_data(in_pixel),
    .rd_addr(rd_addr),
    .rd_data(rd_data)
  );
  // Input is refused once a full line is held, so the final phase1 beat hands over to the replay.
  always_comb begin
    last_col = out_col == LAST_COL;
    last_row = out_row == LAST_ROW;
    last_in_row = in_row == COORD_W'(IN_H - 1);
    in_ready = state == EVEN && in_col != COORD_W'(IN_W) && (!out_valid || (out_ready && phase));
    in_fire = in_valid && in_ready;
    out_fire = out_valid && out_ready;
    next_state = state == RPRIME ? ODD : (out_fire && last_col) ? (state == EVEN ? RPRIME : EVEN) : state;
    out_sof = out_valid && out_col == '0 && out_row == '0;
    out_eol = out_valid && last_col;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= EVEN;
    else state <= next_state;
  // rd_addr rests at 0 outside ODD so entry 0 is already being read when RPRIME begins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_pixel <= '0;
      out_col <= '0;
      out_row <= '0;
      phase <= 1'b0;
      in_col <= '0;
      in_row <= '0;
      rd_addr <= '0;
    end else begin
      if (out_fire) begin
        phase <= !phase;
        out_col <= last_col ? '0 : out_col + 1'b1;
        if (last_col) out_row <= last_row ? '0 : out_row + 1'b1;
        if (phase) out_valid <= 1'b0;
      end
      if (in_fire) begin
        out_pixel <= in_pixel;
        out_valid <= 1'b1;
        phase <= 1'b0;
        in_col <= in_sof ? COORD_W'(1) : in_col + 1'b1;
        if (in_sof) begin
          in_row <= '0;
          out_col <= '0;
          out_row <= '0;
        end
      end
      if (state == RPRIME) begin
        out_pixel <= rd_data;
        out_valid <= 1'b1;
        phase <= 1'b0;
        rd_addr <= AW'(1);
      end
      if (state == ODD && out_fire && phase) begin
        if (last_col) begin
          in_col <= '0;
          in_row <= last_in_row ? '0 : in_row + 1'b1;
        end else begin
          out_pixel <= rd_data;
          out_valid <= 1'b1;
          rd_addr <= rd_addr == AW'(IN_W - 1) ? '0 : rd_addr + 1'b1;
        end
      end
    end
  end
endmodule

// File: doc/gray_upscale2x.md
Name: gray_upscale2x

Overview:
- Inverse of the Bayer-to-gray decimator: takes the half-resolution gray stream (one pixel per 2x2 raw quad) and rebuilds a full-resolution stream by 2x nearest-neighbour replication.
- Sits downstream of the gray converter, feeding display/VGA-side logic that expects 1280x960 raster order.
- Buffers one gray line and replays it for the odd output row.

Parameters:
- DATA_WIDTH, 12, pixel width.
- IN_W, 640, gray pixels per input line. Output width is 2*IN_W.
- IN_H, 480, gray lines per frame. Output height is 2*IN_H.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- in_pixel  in  DATA_WIDTH  gray pixel.
- in_valid  in  1  in_pixel valid.
- in_sof  in  1  marks first pixel of a frame; qualified by in_valid.
- in_ready  out  1  block accepts in_pixel this cycle.
- out_pixel  out  DATA_WIDTH  replicated pixel.
- out_valid  out  1  output valid.
- out_ready  in  1  downstream accepts.
- out_col  out  16  output column, 0..2*IN_W-1.
- out_row  out  16  output row, 0..2*IN_H-1.
- out_sof  out  1  high with the pixel at (0,0).
- out_eol  out  1  high when out_col == 2*IN_W-1.

Behaviour:
- Transfers: input on in_valid && in_ready; output on out_valid && out_ready.
- out_valid is held, and out_pixel/out_col/out_row are stable, until a transfer occurs.
- Reset values: out_valid=0, out_pixel=0, out_col=0, out_row=0, phase=0, in_col=0, in_row=0, state=EVEN. Reset mid-line discards all buffered data; the next input is treated as (0,0).
- Output holding register carries a dup phase bit:
  - phase0 = left copy (column 2k).
  - phase1 = right copy (column 2k+1).
- State EVEN (output row 2r):
  - in_ready = !out_valid || (out_ready && phase==1). Combinational; low in every other state.
  - On input transfer: out_pixel <= in_pixel, out_valid <= 1, phase <= 0, linebuf[in_col] <= in_pixel, in_col++.
  - On an output transfer in phase0: phase <= 1.
  - On an output transfer in phase1 with no input transfer: out_valid <= 0.
  - Throughput: 1 input per 2 output cycles; 1 cycle latency from input to first output copy.
- EVEN -> RPRIME when the output transfer at out_col == 2*IN_W-1 occurs.
- RPRIME:
  - One-cycle bubble. Entered with rd_addr=0 already issued; linebuf is registered-read with 1-cycle latency.
  - Next cycle: out_pixel <= rd_data, phase <= 0, out_valid <= 1, rd_addr <= 1. Go to ODD.
- ODD (output row 2r+1):
  - Replays linebuf entries 0..IN_W-1, each twice.
  - On the phase1 transfer of entry k (k < IN_W-1): out_pixel <= rd_data (entry k+1), and rd_addr <= k+2 is issued in the same edge.
  - Data is always ready in time, because a phase0 transfer plus a phase1 transfer take at least 2 cycles after the load.
  - At the phase1 transfer of entry IN_W-1: out_valid <= 0, in_row++, in_col <= 0, go to EVEN.
  - If in_row wraps at IN_H, in_row <= 0 and out_row <= 0.
- Coordinates:
  - out_col increments on every output transfer and wraps to 0 after 2*IN_W-1.
  - out_row increments at each line wrap and wraps to 0 after 2*IN_H-1.
- Frame realign: an input transfer with in_sof=1 forces in_col=0, in_row=0, and the loaded pixel's coordinates to (0,0). Any partial line in progress is abandoned (no replay). Only legal in EVEN, since in_ready is low elsewhere.
- in_sof on a transfer while in_col == 0 and in_row == 0 is a no-op.
- Backpressure: out_ready=0 for any duration freezes everything; no data is lost or duplicated.

Decomposition:
- Package gray_pkg holds:
  - DATA_WIDTH and the IN_W/IN_H defaults.
  - The state enum {EVEN, RPRIME, ODD}.
  - The coordinate width constant (16).
- One sub-module, gray_linebuf: single-port-write / single-port-read RAM, depth IN_W, width DATA_WIDTH, synchronous write, registered read, no reset on storage.

Test Plan:
- Small config IN_W=4, IN_H=2, out_ready=1, one line A,B,C,D streamed back-to-back:
  - Row 0 = A,A,B,B,C,C,D,D.
  - Then 1 bubble cycle, then row 1 = A,A,B,B,C,C,D,D.
  - out_eol high on col 7 of each row; in_ready low during the bubble and row 1.
- Full frame of 2 lines (second line E,F,G,H):
  - Rows 2 and 3 are both E,E,F,F,G,G,H,H.
  - After row 3, out_row wraps to 0; out_sof high on the next (0,0) pixel.
- Random out_ready (about 50% duty) over 3 frames: output sequence matches the scoreboard exactly; out_pixel/out_col/out_row stable whenever out_valid && !out_ready.
- in_sof asserted on the 3rd pixel of line 1: that pixel emits at (0,0) with out_sof=1; the abandoned line produces no odd-row replay.
- rst asserted during an ODD replay at out_col=5: out_valid=0 next cycle; after release, the first input emits at (0,0).
- Default 640x480, input held continuously valid: in_ready toggles 1,0 during EVEN; 1281 cycles between the EVEN->RPRIME transition and return to EVEN.
